// File: rtl/word_beat_if.sv
// Word-in / beat-out handshake bundle for the word-to-beat serializer.
interface word_beat_if #(
    parameter int IN_W  = 53,
    parameter int OUT_W = 12
);
    logic [IN_W-1:0]  word_data;
    logic             word_valid;
    logic             word_ready;
    logic [OUT_W-1:0] beat_data;
    logic             beat_valid;
    logic             beat_ready;
    logic             beat_last;
    logic [2:0]       beat_idx;

    modport slave (
        input  word_data, word_valid, beat_ready,
        output word_ready, beat_data, beat_valid, beat_last, beat_idx
    );
    modport master (
        output word_data, word_valid, beat_ready,
        input  word_ready, beat_data, beat_valid, beat_last, beat_idx
    );
endinterface

// File: rtl/word_beat_serializer.sv
// Splits an IN_W-bit word into OUT_W-bit beats, LSB first, with an optional
// trailing XOR check beat; back-to-back words stream without a bubble.
module word_beat_serializer #(
    parameter int IN_W      = 53,
    parameter int OUT_W     = 12,
    parameter int ADD_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    word_beat_if.slave  bus,
    output logic [15:0] words_done
);
    localparam int NBEATS = (IN_W + OUT_W - 1) / OUT_W;
    localparam int PAD_W  = NBEATS * OUT_W;
    localparam logic [2:0] LAST_IDX = 3'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, SEND, CHECK} state_t;

    state_t                          state_q, state_n;
    logic [NBEATS-1:0][OUT_W-1:0]    word_q;
    logic [2:0]                      idx_q;
    logic [OUT_W-1:0]                csum_q;
    logic [OUT_W-1:0]                cur_beat;
    logic [OUT_W-1:0]                data;
    logic                            vld, last, fire, load, wrdy;

    always_comb begin
        cur_beat = '0;
        for (int i = 0; i < NBEATS; i++)
            if (idx_q == 3'(i)) cur_beat = word_q[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        vld     = 1'b0;
        last    = 1'b0;
        data    = '0;
        case (state_q)
            SEND: begin
                vld  = 1'b1;
                data = cur_beat;
                last = (ADD_CHECK == 0) && (idx_q == LAST_IDX);
                if (bus.beat_ready && idx_q == LAST_IDX)
                    state_n = (ADD_CHECK != 0) ? CHECK : IDLE;
            end
            CHECK: begin
                vld  = 1'b1;
                data = csum_q;
                last = 1'b1;
                if (bus.beat_ready) state_n = IDLE;
            end
            default: ;
        endcase
        fire = vld && bus.beat_ready;
        // Accepting during the final handshake lets the next word follow with no gap.
        wrdy = rst_n && (state_q == IDLE || (fire && last));
        load = bus.word_valid && wrdy;
        if (load) state_n = SEND;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q     <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            words_done <= '0;
        end else begin
            if (fire && last) words_done <= words_done + 16'd1;
            if (load) begin
                word_q <= PAD_W'(bus.word_data);
                idx_q  <= '0;
                csum_q <= '0;
            end else if (fire) begin
                if (last) begin
                    idx_q  <= '0;
                    csum_q <= '0;
                end else begin
                    idx_q  <= idx_q + 3'd1;
                    csum_q <= csum_q ^ data;
                end
            end
        end
    end

    assign bus.word_ready = wrdy;
    assign bus.beat_valid = vld;
    assign bus.beat_data  = data;
    assign bus.beat_last  = last;
    assign bus.beat_idx   = idx_q;
endmodule

// File: tb/tb_word_beat_serializer.sv
// Randomized bench for word_beat_serializer: with- and without-check instances, arithmetic reference model.
module tb_word_beat_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic [52:0] word_data;
    logic        word_valid, beat_ready;
    logic [15:0] done1, done0;

    word_beat_if #(.IN_W(53), .OUT_W(12)) if1 ();
    word_beat_if #(.IN_W(53), .OUT_W(12)) if0 ();

    word_beat_serializer #(.IN_W(53), .OUT_W(12), .ADD_CHECK(1)) u_chk (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .words_done(done1));
    word_beat_serializer #(.IN_W(53), .OUT_W(12), .ADD_CHECK(0)) u_nochk (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .words_done(done0));

    assign if1.word_data  = word_data;
    assign if1.word_valid = word_valid & sel;
    assign if1.beat_ready = beat_ready & sel;
    assign if0.word_data  = word_data;
    assign if0.word_valid = word_valid & ~sel;
    assign if0.beat_ready = beat_ready & ~sel;

    logic [11:0] m_bd;
    logic [2:0]  m_bi;
    logic        m_bv, m_bl, m_wr;
    assign m_bd = sel ? if1.beat_data  : if0.beat_data;
    assign m_bi = sel ? if1.beat_idx   : if0.beat_idx;
    assign m_bv = sel ? if1.beat_valid : if0.beat_valid;
    assign m_bl = sel ? if1.beat_last  : if0.beat_last;
    assign m_wr = sel ? if1.word_ready : if0.word_ready;

    int vec = 0;
    int miss = 0;

    logic [52:0] wq[$];
    logic [52:0] ew[$];
    logic [11:0] cap_data[$];
    logic [2:0]  cap_idx[$];
    bit          cap_last[$];
    bit          cap_wrdy[$];
    int          cap_cyc[$];
    int          stab_err;
    bit          to_flag;

    // Reference: beat b is bits [12b+11:12b] of the word, check beat is the XOR of the five.
    function automatic logic [15:0] exp_triple(input logic [52:0] w, input int b, input bit chk);
        logic [52:0] t;
        logic [11:0] d;
        d = '0;
        if (b < 5) begin
            t = w >> (12 * b);
            d = t[11:0];
        end else begin
            for (int i = 0; i < 5; i++) begin
                t = w >> (12 * i);
                d ^= t[11:0];
            end
        end
        return {d, 3'(b), (b == (chk ? 5 : 4))};
    endfunction

    function automatic logic [52:0] rand_word();
        return 53'({$urandom, $urandom});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; word_valid = 1'b0; beat_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives words from wq and captures every accepted beat until exp_beats are seen.
    task automatic run_words(input int rdy_pct, input int gap_pct, input int exp_beats);
        logic [52:0] cur;
        bit          have, pstall;
        logic [11:0] pd;
        logic [2:0]  pi;
        logic        pl;
        int          n;
        have = 0; pstall = 0; pd = '0; pi = '0; pl = 1'b0; n = 0;
        cur = '0; to_flag = 0; stab_err = 0;
        cap_data.delete(); cap_idx.delete(); cap_last.delete();
        cap_wrdy.delete(); cap_cyc.delete();
        while (cap_data.size() < exp_beats) begin
            if (n >= 20000) begin to_flag = 1; break; end
            @(negedge clk);
            if (!have && wq.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                cur = wq.pop_front(); have = 1;
            end
            word_valid = have;
            word_data  = have ? cur : rand_word();
            beat_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (pstall && (m_bd !== pd || m_bi !== pi || m_bl !== pl || m_bv !== 1'b1))
                stab_err++;
            if (word_valid && m_wr) have = 0;
            if (m_bv && beat_ready) begin
                cap_data.push_back(m_bd); cap_idx.push_back(m_bi);
                cap_last.push_back(m_bl); cap_wrdy.push_back(m_wr);
                cap_cyc.push_back(n);
            end
            pstall = m_bv && !beat_ready;
            pd = m_bd; pi = m_bi; pl = m_bl;
            n++;
        end
        @(negedge clk);
        word_valid = 1'b0; beat_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; word_valid = 1'b1; beat_ready = 1'b1; word_data = rand_word();
        #1;
        vec++; if (m_wr !== 1'b0) begin miss++; $display("FAIL rst_wrdy_low: got %b expected 0", m_wr); end
        @(negedge clk); #1;
        vec++;
        if ({m_bv, m_bd, m_bi, m_bl} !== 17'd0) begin
            miss++; $display("FAIL rst_outputs: got v=%b d=%h i=%0d l=%b expected all 0", m_bv, m_bd, m_bi, m_bl);
        end
        vec++;
        if ({done1, done0} !== 32'd0) begin
            miss++; $display("FAIL rst_done: got %h/%h expected 0/0", done1, done0);
        end
        rst_n = 1'b1; word_valid = 1'b0; beat_ready = 1'b0;
        #1;
        vec++; if (m_wr !== 1'b1) begin miss++; $display("FAIL idle_wrdy_chk: got %b expected 1", m_wr); end
        sel = 1'b0; #1;
        vec++; if (m_wr !== 1'b1) begin miss++; $display("FAIL idle_wrdy_nochk: got %b expected 1", m_wr); end
        sel = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        sel = 1'b1;
        ew.delete(); ew.push_back(53'h0ABC); wq.push_back(53'h0ABC);
        run_words(100, 0, 6);
        vec++; if (to_flag) begin miss++; $display("FAIL basic_timeout: got %0d beats expected 6", cap_data.size()); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k]} !== exp_triple(ew[0], k, 1)) begin
                miss++; $display("FAIL basic_beat%0d: got %h expected %h", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, exp_triple(ew[0], k, 1));
            end
        end
        if (cap_data.size() == 6) begin
            vec++; if (cap_data[5] !== 12'hABC) begin miss++; $display("FAIL basic_check: got %h expected abc", cap_data[5]); end
        end
        @(negedge clk);
        vec++; if (done1 !== 16'd1) begin miss++; $display("FAIL basic_done: got %0d expected 1", done1); end
    endtask

    task automatic test_all_ones();
        logic [52:0] w;
        w = '1;
        sel = 1'b1;
        ew.delete(); ew.push_back(w); wq.push_back(w);
        run_words(100, 0, 6);
        vec++; if (to_flag) begin miss++; $display("FAIL ones_timeout: got %0d beats expected 6", cap_data.size()); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k]} !== exp_triple(w, k, 1)) begin
                miss++; $display("FAIL ones_beat%0d: got %h expected %h", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, exp_triple(w, k, 1));
            end
        end
        if (cap_data.size() == 6) begin
            vec++;
            if ({cap_data[4], cap_data[5]} !== {12'h01F, 12'h01F}) begin
                miss++; $display("FAIL ones_pad: got %h %h expected 01f 01f", cap_data[4], cap_data[5]);
            end
        end
        @(negedge clk);
        vec++; if (done1 !== 16'd2) begin miss++; $display("FAIL ones_done: got %0d expected 2", done1); end
    endtask

    task automatic test_no_check();
        logic [52:0] w;
        int extra;
        w = 53'h1_2345_6789_ABCD;
        do_reset();
        sel = 1'b0;
        ew.delete(); ew.push_back(w); wq.push_back(w);
        run_words(100, 0, 5);
        vec++; if (to_flag) begin miss++; $display("FAIL nochk_timeout: got %0d beats expected 5", cap_data.size()); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k]} !== exp_triple(w, k, 0)) begin
                miss++; $display("FAIL nochk_beat%0d: got %h expected %h", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, exp_triple(w, k, 0));
            end
        end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            beat_ready = 1'b1; #1;
            if (m_bv) extra++;
            @(negedge clk);
        end
        beat_ready = 1'b0;
        vec++; if (extra !== 0) begin miss++; $display("FAIL nochk_no_6th: got %0d extra valid cycles expected 0", extra); end
        vec++; if (done0 !== 16'd1) begin miss++; $display("FAIL nochk_done: got %0d expected 1", done0); end
        // Random words with stalls through the no-check instance.
        ew.delete();
        for (int i = 0; i < 20; i++) begin w = rand_word(); ew.push_back(w); wq.push_back(w); end
        run_words(60, 30, 100);
        vec++; if (to_flag) begin miss++; $display("FAIL nochk_rand_timeout: got %0d beats expected 100", cap_data.size()); end
        vec++; if (stab_err !== 0) begin miss++; $display("FAIL nochk_stable: got %0d unstable stalls expected 0", stab_err); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k]} !== exp_triple(ew[k/5], k%5, 0)) begin
                miss++; $display("FAIL nochk_rand_beat%0d: got %h expected %h", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, exp_triple(ew[k/5], k%5, 0));
            end
        end
        @(negedge clk);
        vec++; if (done0 !== 16'd21) begin miss++; $display("FAIL nochk_rand_done: got %0d expected 21", done0); end
    endtask

    task automatic test_random_backpressure();
        logic [52:0] w;
        logic [15:0] d0;
        sel = 1'b1;
        d0 = done1;
        ew.delete();
        for (int i = 0; i < 100; i++) begin w = rand_word(); ew.push_back(w); wq.push_back(w); end
        run_words(50, 25, 600);
        vec++; if (to_flag) begin miss++; $display("FAIL rand_timeout: got %0d beats expected 600", cap_data.size()); end
        vec++; if (stab_err !== 0) begin miss++; $display("FAIL rand_stable: got %0d unstable stalls expected 0", stab_err); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k]} !== exp_triple(ew[k/6], k%6, 1)) begin
                miss++; $display("FAIL rand_beat%0d: got %h expected %h", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, exp_triple(ew[k/6], k%6, 1));
            end
        end
        @(negedge clk);
        vec++;
        if (16'(done1 - d0) !== 16'd100) begin
            miss++; $display("FAIL rand_done: got %0d expected 100", 16'(done1 - d0));
        end
    endtask

    task automatic test_back_to_back();
        logic [52:0] w;
        do_reset();
        sel = 1'b1;
        ew.delete();
        for (int i = 0; i < 2; i++) begin w = rand_word(); ew.push_back(w); wq.push_back(w); end
        run_words(100, 0, 12);
        vec++; if (to_flag) begin miss++; $display("FAIL b2b_timeout: got %0d beats expected 12", cap_data.size()); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k], cap_wrdy[k]} !==
                {exp_triple(ew[k/6], k%6, 1), (k == 5 || k == 11)}) begin
                miss++; $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, cap_wrdy[k],
                                 exp_triple(ew[k/6], k%6, 1), (k == 5 || k == 11));
            end
        end
        if (cap_cyc.size() == 12) begin
            vec++;
            if (cap_cyc[11] - cap_cyc[0] !== 11) begin
                miss++; $display("FAIL b2b_span: got %0d cycles expected 11", cap_cyc[11] - cap_cyc[0]);
            end
        end
        @(negedge clk);
        vec++; if (done1 !== 16'd2) begin miss++; $display("FAIL b2b_done: got %0d expected 2", done1); end
    endtask

    task automatic test_reset_mid_word();
        logic [52:0] w;
        bit found;
        do_reset();
        sel = 1'b1;
        found = 0;
        @(negedge clk);
        word_valid = 1'b1; word_data = rand_word(); beat_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            word_valid = 1'b0;
            #1;
            if (m_bv && m_bi == 3'd2) begin found = 1; break; end
        end
        vec++; if (!found) begin miss++; $display("FAIL mid_reach_beat2: got idx %0d expected 2", m_bi); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        vec++; if (m_bv !== 1'b0) begin miss++; $display("FAIL mid_valid: got %b expected 0", m_bv); end
        vec++; if (done1 !== 16'd0) begin miss++; $display("FAIL mid_done: got %0d expected 0", done1); end
        rst_n = 1'b1; beat_ready = 1'b0;
        w = rand_word();
        ew.delete(); ew.push_back(w); wq.push_back(w);
        run_words(70, 0, 6);
        vec++; if (to_flag) begin miss++; $display("FAIL mid_timeout: got %0d beats expected 6", cap_data.size()); end
        for (int k = 0; k < cap_data.size(); k++) begin
            vec++;
            if ({cap_data[k], cap_idx[k], cap_last[k]} !== exp_triple(w, k, 1)) begin
                miss++; $display("FAIL mid_beat%0d: got %h expected %h", k,
                                 {cap_data[k], cap_idx[k], cap_last[k]}, exp_triple(w, k, 1));
            end
        end
        @(negedge clk);
        vec++; if (done1 !== 16'd1) begin miss++; $display("FAIL mid_after_done: got %0d expected 1", done1); end
    endtask

    initial begin
        rst_n = 1'b1; sel = 1'b1; word_valid = 1'b0; beat_ready = 1'b0; word_data = '0;
        test_reset();
        test_basic();
        test_all_ones();
        test_no_check();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
